// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the byte-wide ingress path and the
// 32-bit datapath it feeds.
package axis_pkg;

    localparam int AXIS_BYTE_W  = 8;
    localparam int AXIS_RATIO   = 4;
    localparam int AXIS_WORD_W  = AXIS_BYTE_W * AXIS_RATIO;

    // Widest keep mask keep_mask() can describe; callers size-cast the
    // result down to their own lane count.
    localparam int KEEP_MASK_W  = 64;

    // One packed output beat at the default width.
    typedef struct packed {
        logic [AXIS_WORD_W-1:0] data;
        logic [AXIS_RATIO-1:0]  keep;
        logic                   last;
    } axis_word_t;

    // Thermometer mask with lanes 0..cnt set, i.e. (2^(cnt+1))-1.
    function automatic logic [KEEP_MASK_W-1:0] keep_mask(input int cnt);
        logic [KEEP_MASK_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_MASK_W; i++) begin
            mask[i] = (i <= cnt);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// AXI-Stream width upsizer: packs consecutive IN_WIDTH-bit beats into
// RATIO-lane words, little-endian (first beat in lane 0). A beat carrying
// tlast closes the word early; unused upper lanes are zero and tkeep
// marks the valid ones.
//
// Handshake: a beat moves on either port only in a cycle where valid and
// ready are both high at the rising edge. Valid never waits for ready and,
// once raised on the output, is held with its payload unchanged until the
// beat is taken. s_axis_tready depends only on reset, the registered
// output valid and m_axis_tready, never on s_axis_tvalid.
module axis_byte_packer
    import axis_pkg::*;
#(
    parameter int IN_WIDTH  = AXIS_BYTE_W,
    parameter int RATIO     = AXIS_RATIO,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic [RATIO-1:0]     m_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int              CNT_W   = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [RATIO-1:0]     keep;
        logic                 last;
    } beat_t;

    // Packing state: next lane to fill and the bytes collected so far.
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] partial_q, partial_d;

    // Output register.
    beat_t                out_q, out_d;
    logic                 out_valid_q, out_valid_d;

    logic                 s_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic                 beat_completes;
    logic                 load_word;
    logic [OUT_WIDTH-1:0] word_next;
    logic [RATIO-1:0]     keep_next;

    // Handshake decode; the input may only advance when the output slot is
    // empty or being drained this cycle.
    always_comb begin
        s_ready        = !reset && (!out_valid_q || m_axis_tready);
        in_fire        = s_axis_tvalid && s_ready;
        out_fire       = out_valid_q && m_axis_tready;
        beat_completes = (cnt_q == CNT_MAX) || s_axis_tlast;
        load_word      = in_fire && beat_completes;
    end

    // Lane packing: assemble the candidate word and advance the lane counter.
    always_comb begin
        cnt_d     = cnt_q;
        partial_d = partial_q;
        word_next = '0;
        keep_next = RATIO'(keep_mask(int'(cnt_q)));

        // Lanes below cnt come from the partial register, lane cnt takes the
        // incoming beat, lanes above stay zero.
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(cnt_q)) begin
                word_next[i*IN_WIDTH +: IN_WIDTH] = partial_q[i*IN_WIDTH +: IN_WIDTH];
            end else if (i == int'(cnt_q)) begin
                word_next[i*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
            end
        end

        if (in_fire) begin
            if (beat_completes) begin
                cnt_d     = '0;
                partial_d = '0;
            end else begin
                partial_d[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Packing state register; reset discards any partially collected word.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            partial_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

    // Output slot next state: drain on consume, reload on a completing beat
    // (a reload in the same cycle as a drain keeps valid high, no bubble).
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (load_word) begin
            out_d.data  = word_next;
            out_d.keep  = keep_next;
            out_d.last  = s_axis_tlast;
            out_valid_d = 1'b1;
        end
    end

    // Output register, kept apart from the packing logic so a skid stage
    // can be slotted in here later.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer: directed packets plus a randomised stream
// with random backpressure, checked through an expected-word queue.
module tb_axis_byte_packer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    axis_byte_packer dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
    );

    // ---------------- scoreboard state ----------------
    logic [36:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cycles = 0;

    // 0: hold low, 1: hold high, 2: random
    int          rdy_mode = 1;

    // reference packer, used by the randomised section only
    bit          use_model = 1'b0;
    logic [31:0] mdl_acc = '0;
    int          mdl_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [3:0] keep, input logic last);
        exp_q.push_back({data, keep, last});
    endtask

    // ---------------- driver ----------------
    // Present one byte from a falling edge and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input logic l);
        int waits;
        logic [3:0] k;
        waits = 0;
        @(negedge clk);
        s_tdata  = b;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (!s_tready) begin
            waits++;
            stall_cycles++;
            if (waits > 200) begin
                check_eq("send_timeout", 64'(waits), 64'd0);
                s_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        if (use_model) begin
            mdl_acc[mdl_cnt*8 +: 8] = b;
            if (mdl_cnt == 3 || l) begin
                k = 4'((1 << (mdl_cnt + 1)) - 1);
                push_exp(mdl_acc, k, l);
                mdl_acc = '0;
                mdl_cnt = 0;
            end else begin
                mdl_cnt++;
            end
        end
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Downstream ready, changed just after the rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [36:0] e;
        #2;
        if (!reset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", {27'd0, m_tdata, m_tkeep, m_tlast}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("word", {27'd0, m_tdata, m_tkeep, m_tlast}, {27'd0, e});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tdata",  64'(m_tdata),  64'd0);
        check_eq("rst_tkeep",  64'(m_tkeep),  64'd0);
        check_eq("rst_tlast",  64'(m_tlast),  64'd0);
        check_eq("rst_sready", 64'(s_tready), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("sready_after_rst", 64'(s_tready), 64'd1);

        // 1: full word, latency
        push_exp(32'h44332211, 4'hF, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check_eq("t1_no_early_valid", 64'(m_tvalid), 64'd0);
        send_byte(8'h44, 1'b1);
        check_eq("t1_valid_next", 64'(m_tvalid), 64'd1);

        // 2: six-byte packet, short tail
        push_exp(32'hA4A3A2A1, 4'hF, 1'b0);
        push_exp(32'h0000A6A5, 4'h3, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'hA0 + 8'(i), i == 6);
        end

        // 3: single-byte packet
        push_exp(32'h0000005A, 4'h1, 1'b1);
        send_byte(8'h5A, 1'b1);

        // 4: backpressure with an ignored beat offered during the stall
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        push_exp(32'h04030201, 4'hF, 1'b1);
        push_exp(32'h00000005, 4'h1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), i == 4);
        end
        @(negedge clk);
        s_tdata  = 8'hEE;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("bp_sready", 64'(s_tready), 64'd0);
            check_eq("bp_tvalid", 64'(m_tvalid), 64'd1);
            check_eq("bp_tdata",  64'(m_tdata),  64'h04030201);
            check_eq("bp_tkeep",  64'(m_tkeep),  64'hF);
            check_eq("bp_tlast",  64'(m_tlast),  64'd1);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rdy_mode = 1;
        @(posedge clk);
        #2;
        check_eq("bp_release_sready", 64'(s_tready), 64'd1);
        send_byte(8'h05, 1'b1);

        // 5: continuous 16-byte stream, no stall allowed
        push_exp(32'h03020100, 4'hF, 1'b0);
        push_exp(32'h07060504, 4'hF, 1'b0);
        push_exp(32'h0B0A0908, 4'hF, 1'b0);
        push_exp(32'h0F0E0D0C, 4'hF, 1'b1);
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), i == 15);
        end
        check_eq("stream_stalls", 64'(stall_cycles), 64'd0);

        // 6: reset mid-packet discards partial bytes
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_sready", 64'(s_tready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        push_exp(32'hD4D3D2D1, 4'hF, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'hD0 + 8'(i), i == 4);
        end

        // 7: random bytes, tlast, gaps and backpressure against the model
        repeat (4) @(negedge clk);
        use_model = 1'b1;
        rdy_mode  = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0) || (i == 59));
        end
        rdy_mode = 1;

        begin
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 200) begin
                @(posedge clk);
                w++;
            end
        end
        repeat (2) @(negedge clk);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        check_eq("global_timeout", 64'd1, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
